// File: rtl/inst_fetch_queue.sv
// -----------------------------------------------------------------------------
// inst_fetch_queue
//
// Instruction fetch front end. A PC register walks instruction memory one word
// at a time over a req/ack handshake with variable latency. Fetched words are
// buffered in a DEPTH-entry FIFO together with their PC and handed to the
// decoder over a valid/ready handshake. A branch/jump redirect flushes the FIFO
// and restarts fetching at the new PC. If a redirect arrives while a request is
// still waiting for its ack, that request is allowed to finish on the bus (the
// address stays stable) and its data is thrown away.
//
// Optional build macro:
//   IFQ_BYPASS_EN - when the FIFO is empty, a word acked in REQ is shown to the
//                   decoder in the same cycle; if the decoder takes it, it is
//                   never written into the FIFO. Undefined: no combinational
//                   path from imem_* to valid_o/inst_o/pc_o.
//
// Parameters:
//   DEPTH     FIFO entries (power of two, >= 2)
//   RESET_PC  first fetch address after reset
//
// Ports:
//   clk_i          in   clock, rising edge
//   reset_i        in   asynchronous active-high reset
//   redirect_i     in   branch/jump taken: flush and refetch
//   redirect_pc_i  in   new fetch address (bits [1:0] ignored)
//   imem_req_o     out  fetch request
//   imem_addr_o    out  fetch address, stable while a request is outstanding
//   imem_ack_i     in   fetch complete, imem_rdata_i valid this cycle
//   imem_rdata_i   in   fetched instruction word
//   inst_o         out  head-entry instruction (0 when empty)
//   pc_o           out  head-entry PC (0 when empty)
//   return_pc_o    out  pc_o + 4 (0 when empty)
//   valid_o        out  head entry valid
//   ready_i        in   decoder accepts the head entry
//   count_o        out  FIFO occupancy
// -----------------------------------------------------------------------------
module inst_fetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     redirect_i,
    input  logic [31:0]              redirect_pc_i,
    output logic                     imem_req_o,
    output logic [31:0]              imem_addr_o,
    input  logic                     imem_ack_i,
    input  logic [31:0]              imem_rdata_i,
    output logic [31:0]              inst_o,
    output logic [31:0]              pc_o,
    output logic [31:0]              return_pc_o,
    output logic                     valid_o,
    input  logic                     ready_i,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("inst_fetch_queue: DEPTH must be a power of two and at least 2");
    end

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_DROP
    } state_e;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
    } entry_t;

    state_e          r_state;
    state_e          w_state_next;
    logic [31:0]     r_fetch_pc;
    logic [31:0]     r_pend_pc;
    entry_t          r_mem [DEPTH];
    logic [PW-1:0]   r_rd_ptr;
    logic [PW-1:0]   r_wr_ptr;
    logic [CW-1:0]   r_count;
    logic [CW-1:0]   w_count_next;

    logic            w_empty;
    logic            w_ack_req;
    logic            w_bypass_valid;
    logic            w_bypass_take;
    logic            w_push;
    logic            w_pop;
    logic [31:0]     w_redirect_target;

    // Word-align the target; masking keeps every input bit in use.
    assign w_redirect_target = redirect_pc_i & 32'hFFFF_FFFC;

    assign w_empty   = (r_count == '0);
    // An ack is only meaningful in REQ; a redirect in the same cycle kills it.
    assign w_ack_req = (r_state == ST_REQ) && imem_ack_i && !redirect_i;

`ifdef IFQ_BYPASS_EN
    assign w_bypass_valid = w_empty && w_ack_req;
`else
    assign w_bypass_valid = 1'b0;
`endif
    assign w_bypass_take = w_bypass_valid && ready_i;

    assign w_push = w_ack_req && !w_bypass_take;
    // Only stored entries are popped; a bypassed word never enters the FIFO.
    assign w_pop  = !w_empty && ready_i && !redirect_i;

    always_comb begin
        w_count_next = r_count;
        if (redirect_i) begin
            w_count_next = '0;
        end else begin
            unique case ({w_push, w_pop})
                2'b10:   w_count_next = r_count + CW'(1);
                2'b01:   w_count_next = r_count - CW'(1);
                default: w_count_next = r_count;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge reset_i) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge values regardless of block ordering.
        if (reset_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: default assignment first, so no path leaves the signal unassigned
        // and no latch is inferred.
        w_state_next = r_state;
        unique case (r_state)
            ST_IDLE: begin
                // A redirect flushes the FIFO, so there is always room after it.
                if (redirect_i || (r_count < FULL_COUNT)) begin
                    w_state_next = ST_REQ;
                end
            end
            ST_REQ: begin
                if (redirect_i) begin
                    // Without an ack the bus transaction is still open: drain it.
                    w_state_next = imem_ack_i ? ST_REQ : ST_DROP;
                end else if (imem_ack_i) begin
                    w_state_next = (w_count_next < FULL_COUNT) ? ST_REQ : ST_IDLE;
                end
            end
            ST_DROP: begin
                if (imem_ack_i) begin
                    w_state_next = ST_REQ;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM: outputs
    // -------------------------------------------------------------------------
    always_comb begin
        imem_req_o  = (r_state != ST_IDLE);
        imem_addr_o = r_fetch_pc;
    end

    // -------------------------------------------------------------------------
    // Fetch PC. While a stale request drains in DROP, the bus address must stay
    // put, so the redirect target waits in r_pend_pc until the ack.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_fetch_pc <= RESET_PC;
            r_pend_pc  <= RESET_PC;
        end else if (redirect_i) begin
            if ((r_state != ST_IDLE) && !imem_ack_i) begin
                r_pend_pc <= w_redirect_target;
            end else begin
                r_fetch_pc <= w_redirect_target;
            end
        end else if (imem_ack_i) begin
            if (r_state == ST_REQ) begin
                r_fetch_pc <= r_fetch_pc + 32'd4;
            end else if (r_state == ST_DROP) begin
                r_fetch_pc <= r_pend_pc;
            end
        end
    end

    // -------------------------------------------------------------------------
    // FIFO pointers and occupancy. Pointers are PW bits wide, so they wrap
    // modulo DEPTH on their own; the counter disambiguates full from empty.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_count <= w_count_next;
            if (redirect_i) begin
                r_rd_ptr <= '0;
                r_wr_ptr <= '0;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + PW'(1);
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + PW'(1);
                end
            end
        end
    end

    // NOTE: storage is not reset; the occupancy counter alone decides which
    // entries are live, and unreset arrays map onto plain RAM/flops.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= '{inst: imem_rdata_i, pc: r_fetch_pc};
        end
    end

    // -------------------------------------------------------------------------
    // Consumer side: head fields straight from the read pointer, zero when empty.
    // -------------------------------------------------------------------------
    always_comb begin
        valid_o = !w_empty;
        inst_o  = '0;
        pc_o    = '0;
        if (!w_empty) begin
            inst_o = r_mem[r_rd_ptr].inst;
            pc_o   = r_mem[r_rd_ptr].pc;
        end
        if (w_bypass_valid) begin
            valid_o = 1'b1;
            inst_o  = imem_rdata_i;
            pc_o    = r_fetch_pc;
        end
    end

    assign return_pc_o = valid_o ? (pc_o + 32'd4) : 32'd0;
    assign count_o     = r_count;

endmodule

// File: tb/tb_inst_fetch_queue.sv
// -----------------------------------------------------------------------------
// tb_inst_fetch_queue
//
// Directed scenarios followed by a randomized run. A transaction-level model
// (queue of {inst, pc}, next fetch address, stale-request flag) predicts the
// decoder-side outputs and the bus address every cycle. Honours IFQ_BYPASS_EN.
// -----------------------------------------------------------------------------
module tb_inst_fetch_queue;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          CW       = $clog2(DEPTH) + 1;

    logic          clk_i = 1'b0;
    logic          reset_i;
    logic          redirect_i;
    logic [31:0]   redirect_pc_i;
    logic          imem_req_o;
    logic [31:0]   imem_addr_o;
    logic          imem_ack_i;
    logic [31:0]   imem_rdata_i;
    logic [31:0]   inst_o;
    logic [31:0]   pc_o;
    logic [31:0]   return_pc_o;
    logic          valid_o;
    logic          ready_i;
    logic [CW-1:0] count_o;

    always #5 clk_i = ~clk_i;

    inst_fetch_queue #(
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk_i         (clk_i),
        .reset_i       (reset_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_ack_i    (imem_ack_i),
        .imem_rdata_i  (imem_rdata_i),
        .inst_o        (inst_o),
        .pc_o          (pc_o),
        .return_pc_o   (return_pc_o),
        .valid_o       (valid_o),
        .ready_i       (ready_i),
        .count_o       (count_o)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [63:0] q[$];           // {inst, pc}, head at index 0
    logic [31:0] m_pc;           // next address a live request will use
    logic        m_stale;        // outstanding request must be discarded
    logic [31:0] m_stale_addr;   // its address

    // Memory responder
    int          lat_left;
    int          lat_lo;
    int          lat_hi;
    logic [31:0] next_rdata[$];
    int          n_acks;

    // Observation logs
    logic [31:0] pop_pc[$];
    logic [31:0] pop_ret[$];
    logic [31:0] pop_inst[$];
    logic        saw_dead;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_pc         = RESET_PC;
        m_stale      = 1'b0;
        m_stale_addr = RESET_PC;
        lat_left     = -1;
        n_acks       = 0;
        pop_pc.delete();
        pop_ret.delete();
        pop_inst.delete();
        next_rdata.delete();
        saw_dead     = 1'b0;
    endtask

    task automatic drive_resp();
        if (imem_req_o && lat_left < 0) begin
            lat_left = int'($urandom_range(lat_hi, lat_lo));
        end
        if (imem_req_o && lat_left == 0) begin
            imem_ack_i   = 1'b1;
            imem_rdata_i = (next_rdata.size() != 0) ? next_rdata.pop_front() : $urandom;
        end else begin
            imem_ack_i = 1'b0;
        end
    endtask

    task automatic check_outputs();
        logic [31:0] e_inst;
        logic [31:0] e_pc;
        logic [31:0] e_ret;
        logic        e_valid;
        logic        byp;
        int          n;
        n   = q.size();
        byp = 1'b0;
`ifdef IFQ_BYPASS_EN
        byp = (n == 0) && imem_req_o && imem_ack_i && !m_stale && !redirect_i;
`endif
        e_valid = (n != 0) || byp;
        e_inst  = 32'd0;
        e_pc    = 32'd0;
        if (n != 0) begin
            {e_inst, e_pc} = q[0];
        end else if (byp) begin
            e_inst = imem_rdata_i;
            e_pc   = m_pc;
        end
        e_ret = e_valid ? e_pc + 32'd4 : 32'd0;
        check("count", 32'(count_o), 32'(n));
        check("valid", 32'(valid_o), 32'(e_valid));
        check("inst", inst_o, e_inst);
        check("pc", pc_o, e_pc);
        check("return_pc", return_pc_o, e_ret);
        if (imem_req_o) check("addr", imem_addr_o, m_stale ? m_stale_addr : m_pc);
        if (n == DEPTH) check("req_when_full", 32'(imem_req_o), 32'd0);
    endtask

    // One clock cycle with the inputs currently driven.
    task automatic tick();
        logic        req, ack, red, rdy, was_empty, taken;
        logic [31:0] rd, rpc;
        #1;
        check_outputs();
        if (valid_o && ready_i && !redirect_i) begin
            pop_pc.push_back(pc_o);
            pop_ret.push_back(return_pc_o);
            pop_inst.push_back(inst_o);
        end
        if (valid_o && inst_o == 32'hDEAD_BEEF) saw_dead = 1'b1;
        req = imem_req_o;
        ack = imem_ack_i && imem_req_o;
        red = redirect_i;
        rdy = ready_i;
        rd  = imem_rdata_i;
        rpc = redirect_pc_i;
        @(posedge clk_i);
        if (ack) n_acks++;
        if (red) begin
            q.delete();
            if (req && !ack) begin
                if (!m_stale) begin
                    m_stale      = 1'b1;
                    m_stale_addr = m_pc;
                end
            end else begin
                m_stale = 1'b0;
            end
            m_pc = {rpc[31:2], 2'b00};
        end else begin
            was_empty = (q.size() == 0);
            taken     = 1'b0;
            if (!was_empty && rdy) void'(q.pop_front());
            if (ack && m_stale) begin
                m_stale = 1'b0;
            end else if (ack) begin
`ifdef IFQ_BYPASS_EN
                taken = was_empty && rdy;
`endif
                if (!taken) q.push_back({rd, m_pc});
                m_pc = m_pc + 32'd4;
            end
        end
        if (ack) lat_left = -1;
        else if (lat_left > 0) lat_left--;
        @(negedge clk_i);
    endtask

    task automatic cyc();
        drive_resp();
        tick();
    endtask

    task automatic do_reset();
        reset_i       = 1'b1;
        redirect_i    = 1'b0;
        redirect_pc_i = 32'd0;
        imem_ack_i    = 1'b0;
        imem_rdata_i  = 32'd0;
        ready_i       = 1'b0;
        @(posedge clk_i);
        @(negedge clk_i);
        reset_i = 1'b0;
        model_reset();
    endtask

    initial begin
        int waited;
        reset_i       = 1'b1;
        redirect_i    = 1'b0;
        redirect_pc_i = 32'd0;
        imem_ack_i    = 1'b0;
        imem_rdata_i  = 32'd0;
        ready_i       = 1'b0;
        model_reset();
        lat_lo = 0;
        lat_hi = 0;
        #1;
        check("rst_req", 32'(imem_req_o), 32'd0);
        check("rst_addr", imem_addr_o, RESET_PC);
        check("rst_valid", 32'(valid_o), 32'd0);
        check("rst_count", 32'(count_o), 32'd0);
        check("rst_inst", inst_o, 32'd0);
        check("rst_pc", pc_o, 32'd0);
        check("rst_return_pc", return_pc_o, 32'd0);
        @(negedge clk_i);
        @(negedge clk_i);
        reset_i = 1'b0;

        // ---- 1: streaming with 1-cycle acks ---------------------------------
        lat_lo = 0; lat_hi = 0;
        ready_i = 1'b1;
        next_rdata.push_back(32'h0000_0013);
        next_rdata.push_back(32'h0010_0093);
        next_rdata.push_back(32'h0020_0113);
        repeat (6) cyc();
        ready_i = 1'b0;
        check("t1_npop", 32'(pop_pc.size() >= 3), 32'd1);
        if (pop_pc.size() >= 3) begin
            check("t1_pc0", pop_pc[0], 32'h0);
            check("t1_pc1", pop_pc[1], 32'h4);
            check("t1_pc2", pop_pc[2], 32'h8);
            check("t1_ret0", pop_ret[0], 32'h4);
            check("t1_ret1", pop_ret[1], 32'h8);
            check("t1_ret2", pop_ret[2], 32'hC);
            check("t1_inst0", pop_inst[0], 32'h0000_0013);
            check("t1_inst2", pop_inst[2], 32'h0020_0113);
        end

        // ---- 2: fill to DEPTH, then one pop ---------------------------------
        do_reset();
        lat_lo = 0; lat_hi = 0;
        repeat (8) cyc();
        check("t2_acks", 32'(n_acks), 32'd4);
        check("t2_count_full", 32'(count_o), 32'd4);
        check("t2_req_full", 32'(imem_req_o), 32'd0);
        ready_i = 1'b1;
        cyc();
        ready_i = 1'b0;
        check("t2_count_after_pop", 32'(count_o), 32'd3);
        waited = 0;
        while (!imem_req_o && waited < 4) begin
            cyc();
            waited++;
        end
        check("t2_req_again", 32'(imem_req_o), 32'd1);
        check("t2_addr_again", imem_addr_o, 32'h10);

        // ---- 3: redirect while a 3-cycle request is outstanding -------------
        do_reset();
        lat_lo = 3; lat_hi = 3;
        waited = 0;
        while (!(imem_req_o && imem_addr_o == 32'h8) && waited < 40) begin
            cyc();
            waited++;
        end
        check("t3_req8_seen", 32'(imem_req_o && imem_addr_o == 32'h8), 32'd1);
        cyc();
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h0000_0103;
        cyc();
        redirect_i = 1'b0;
        check("t3_flushed", 32'(count_o), 32'd0);
        check("t3_addr_held", imem_addr_o, 32'h8);
        waited = 0;
        while (!(imem_req_o && imem_addr_o == 32'h100) && waited < 10) begin
            cyc();
            waited++;
        end
        check("t3_req100_seen", 32'(imem_req_o && imem_addr_o == 32'h100), 32'd1);
        waited = 0;
        while (!valid_o && waited < 10) begin
            cyc();
            waited++;
        end
        check("t3_first_pc", pc_o, 32'h100);

        // ---- 4: redirect together with ack and pop --------------------------
        do_reset();
        lat_lo = 0; lat_hi = 0;
        waited = 0;
        while (count_o != CW'(3) && waited < 10) begin
            cyc();
            waited++;
        end
        check("t4_count3", 32'(count_o), 32'd3);
        ready_i       = 1'b1;
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h0000_0200;
        cyc();
        check("t4_ack_in_redirect", 32'(n_acks), 32'd4);
        redirect_i = 1'b0;
        ready_i    = 1'b0;
        check("t4_count0", 32'(count_o), 32'd0);
        check("t4_valid0", 32'(valid_o), 32'd0);
        check("t4_req", 32'(imem_req_o), 32'd1);
        check("t4_addr200", imem_addr_o, 32'h200);
        cyc();
        #1;
        check("t4_head_pc", pc_o, 32'h200);

        // ---- 5: asynchronous reset mid-request, late ack --------------------
        do_reset();
        lat_lo = 3; lat_hi = 3;
        waited = 0;
        while (!imem_req_o && waited < 5) begin
            cyc();
            waited++;
        end
        cyc();
        cyc();
        check("t5_outstanding", 32'(imem_req_o), 32'd1);
        #2;
        reset_i = 1'b1;
        #1;
        check("t5_rst_req", 32'(imem_req_o), 32'd0);
        check("t5_rst_addr", imem_addr_o, RESET_PC);
        check("t5_rst_count", 32'(count_o), 32'd0);
        check("t5_rst_valid", 32'(valid_o), 32'd0);
        imem_ack_i   = 1'b1;
        imem_rdata_i = 32'hDEAD_BEEF;
        @(posedge clk_i);
        @(negedge clk_i);
        reset_i = 1'b0;
        model_reset();
        tick();
        imem_ack_i = 1'b0;
        check("t5_late_ack_count", 32'(count_o), 32'd0);
        lat_lo = 0; lat_hi = 0;
        ready_i = 1'b1;
        repeat (8) cyc();
        ready_i = 1'b0;
        check("t5_no_deadbeef", 32'(saw_dead), 32'd0);
        check("t5_npop", 32'(pop_pc.size() >= 1), 32'd1);
        if (pop_pc.size() >= 1) check("t5_first_pc", pop_pc[0], RESET_PC);

`ifdef IFQ_BYPASS_EN
        // ---- 6: same-cycle bypass on an empty FIFO --------------------------
        do_reset();
        lat_lo = 0; lat_hi = 0;
        ready_i = 1'b1;
        cyc();
        next_rdata.push_back(32'h0050_0293);
        drive_resp();
        #1;
        check("t6_byp_valid", 32'(valid_o), 32'd1);
        check("t6_byp_inst", inst_o, 32'h0050_0293);
        check("t6_byp_pc", pc_o, RESET_PC);
        tick();
        check("t6_byp_count", 32'(count_o), 32'd0);
        ready_i = 1'b0;
`endif

        // ---- 7: randomized traffic against the model ------------------------
        do_reset();
        lat_lo = 0; lat_hi = 3;
        for (int i = 0; i < 800; i++) begin
            ready_i       = ($urandom_range(3, 0) != 0);
            redirect_i    = ($urandom_range(24, 0) == 0);
            redirect_pc_i = $urandom;
            cyc();
        end
        redirect_i = 1'b0;
        check("t7_progress", 32'(n_acks > 100), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
